// File: rtl/io_switch_debounce_pkg.sv
// Shared constants for the switch input path. The data memory's I/O decode
// reuses IO_SW_WIDTH so both sides agree on the switch group width.
package io_switch_debounce_pkg;

  localparam int unsigned IO_SW_WIDTH         = 4;
  localparam int unsigned IO_DEBOUNCE_DEFAULT = 1000000;
  localparam int unsigned IO_DEBOUNCE_CNT_W   = 20;

endpackage : io_switch_debounce_pkg

// File: rtl/io_switch_debounce_if.sv
// Switch-port bundle: raw board inputs and the hold control flow into the
// debouncer; stable values, the change pulse and busy flow back out.
interface io_switch_debounce_if #(
  parameter int unsigned WIDTH = io_switch_debounce_pkg::IO_SW_WIDTH
) ();

  logic [WIDTH-1:0] sw_one_raw;
  logic [WIDTH-1:0] sw_two_raw;
  logic             hold;
  logic [WIDTH-1:0] one;
  logic [WIDTH-1:0] two;
  logic             change_pulse;
  logic             busy;

  modport master (
    output sw_one_raw, sw_two_raw, hold,
    input  one, two, change_pulse, busy
  );

  modport slave (
    input  sw_one_raw, sw_two_raw, hold,
    output one, two, change_pulse, busy
  );

endinterface : io_switch_debounce_if

// File: rtl/io_switch_debounce_field.sv
// One switch group: 2-flop synchroniser followed by a whole-word debounce
// filter. A new value is accepted only after DEBOUNCE_CYCLES consecutive
// identical synchronised samples; hold defers acceptance without losing it.
module debounce_field #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  input  logic             hold,
  output logic [WIDTH-1:0] out,
  output logic             update_c,
  output logic             pending_c
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;

  // Next-state: synchroniser shift and candidate/counter filter rules.
  always_comb begin
    s1_d     = raw;
    s2_d     = s1_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    update_c = 1'b0;

    if (s2_q == out_q) begin
      // Bounce back to the accepted value cancels any pending change.
      cnt_d  = '0;
      cand_d = out_q;
    end else if (s2_q != cand_q) begin
      // Any new pattern restarts the count.
      cand_d = s2_q;
      cnt_d  = CNT_ONE;
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (!hold) begin
      out_d    = cand_q;
      cnt_d    = '0;
      update_c = 1'b1;
    end
    // With hold=1 at the last count, cnt parks at CNT_LAST until released.

    pending_c = (cnt_d != '0);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      cand_q <= '0;
      cnt_q  <= '0;
      out_q  <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
    end
  end

  assign out = out_q;

endmodule : debounce_field

// File: rtl/io_switch_debounce.sv
// Debounced switch port for the data memory: two independent switch groups,
// a single-cycle change pulse and a busy flag covering both groups.
// DEBOUNCE_CYCLES must be >= 2 and fit in CNT_W bits.
module io_switch_debounce
  import io_switch_debounce_pkg::*;
#(
  parameter int unsigned WIDTH           = IO_SW_WIDTH,
  parameter int unsigned DEBOUNCE_CYCLES = IO_DEBOUNCE_DEFAULT,
  parameter int unsigned CNT_W           = IO_DEBOUNCE_CNT_W
) (
  input  logic                 clock,
  input  logic                 reset,
  io_switch_debounce_if.slave  sw
);

  logic [WIDTH-1:0] one_w, two_w;
  logic             upd_one_c, upd_two_c;
  logic             pend_one_c, pend_two_c;

  logic change_pulse_q, change_pulse_d;
  logic busy_q, busy_d;

  debounce_field #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_field_one (
    .clock    (clock),
    .reset    (reset),
    .raw      (sw.sw_one_raw),
    .hold     (sw.hold),
    .out      (one_w),
    .update_c (upd_one_c),
    .pending_c(pend_one_c)
  );

  debounce_field #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_field_two (
    .clock    (clock),
    .reset    (reset),
    .raw      (sw.sw_two_raw),
    .hold     (sw.hold),
    .out      (two_w),
    .update_c (upd_two_c),
    .pending_c(pend_two_c)
  );

  // Combine per-group strobes; simultaneous updates merge into one pulse.
  always_comb begin
    change_pulse_d = upd_one_c | upd_two_c;
    busy_d         = pend_one_c | pend_two_c;
  end

  // Status registers, aligned with the edge on which outputs change.
  always_ff @(posedge clock) begin
    if (reset) begin
      change_pulse_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      change_pulse_q <= change_pulse_d;
      busy_q         <= busy_d;
    end
  end

  assign sw.one          = one_w;
  assign sw.two          = two_w;
  assign sw.change_pulse = change_pulse_q;
  assign sw.busy         = busy_q;

endmodule : io_switch_debounce

// File: tb/tb_io_switch_debounce.sv
// Bench for io_switch_debounce with DEBOUNCE_CYCLES=4, CNT_W=3.
// Directed phase table plus randomized traffic, every cycle checked against
// a run-length reference model of the debouncer.
module tb_io_switch_debounce;

  localparam int unsigned W  = 4;
  localparam int unsigned D  = 4;
  localparam int unsigned CW = 3;

  logic clk = 1'b0;
  logic rst;
  logic [W-1:0] in_a, in_b;
  logic in_hold;

  always #5 clk = ~clk;

  io_switch_debounce_if #(.WIDTH(W)) sw_if ();

  assign sw_if.sw_one_raw = in_a;
  assign sw_if.sw_two_raw = in_b;
  assign sw_if.hold       = in_hold;

  io_switch_debounce #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (CW)
  ) dut (
    .clock(clk),
    .reset(rst),
    .sw   (sw_if)
  );

  int checks   = 0;
  int failures = 0;
  int pulses_seen;

  // Reference model: raw values pass through a 2-deep delay line; a group
  // accepts a value once it has been seen D times in a row (differing from
  // the current output) and hold is low on that edge.
  logic [W-1:0] m_dly1[2];
  logic [W-1:0] m_dly2[2];
  logic [W-1:0] m_out[2];
  logic [W-1:0] m_runval[2];
  int           m_run[2];
  logic         m_pulse;
  logic         m_busy;

  task automatic model_edge();
    logic [W-1:0] raw_now[2];
    logic [W-1:0] seen;
    logic         upd[2];
    raw_now[0] = in_a;
    raw_now[1] = in_b;
    for (int g = 0; g < 2; g++) begin
      upd[g] = 1'b0;
      if (rst) begin
        m_dly1[g] = '0; m_dly2[g] = '0; m_out[g] = '0;
        m_runval[g] = '0; m_run[g] = 0;
      end else begin
        seen = m_dly2[g];
        if (seen == m_out[g]) m_run[g] = 0;
        else if (m_run[g] > 0 && seen == m_runval[g]) m_run[g] = m_run[g] + 1;
        else begin
          m_runval[g] = seen;
          m_run[g] = 1;
        end
        if (m_run[g] >= int'(D) && !in_hold) begin
          m_out[g] = seen;
          m_run[g] = 0;
          upd[g]   = 1'b1;
        end
        m_dly2[g] = m_dly1[g];
        m_dly1[g] = raw_now[g];
      end
    end
    m_pulse = rst ? 1'b0 : (upd[0] | upd[1]);
    m_busy  = rst ? 1'b0 : ((m_run[0] > 0) || (m_run[1] > 0));
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance model on the edge, compare outputs on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (sw_if.change_pulse === 1'b1) pulses_seen++;
    check("model_one",   32'(sw_if.one),          32'(m_out[0]));
    check("model_two",   32'(sw_if.two),          32'(m_out[1]));
    check("model_pulse", 32'(sw_if.change_pulse), 32'(m_pulse));
    check("model_busy",  32'(sw_if.busy),         32'(m_busy));
  endtask

  typedef struct {
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         hold;
    int           cycles;
    logic [W-1:0] exp_one;
    logic [W-1:0] exp_two;
    int           exp_busy;    // -1: not checked at end of phase
    int           exp_pulses;  // pulse cycles observed during the phase
  } phase_t;

  phase_t ph[$];

  task automatic add(input logic r, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic h, input int n, input logic [W-1:0] eo,
                     input logic [W-1:0] et, input int eb, input int ep);
    phase_t p;
    p.rst = r; p.a = a; p.b = b; p.hold = h; p.cycles = n;
    p.exp_one = eo; p.exp_two = et; p.exp_busy = eb; p.exp_pulses = ep;
    ph.push_back(p);
  endtask

  initial begin
    rst = 1'b1; in_a = 4'hF; in_b = 4'h0; in_hold = 1'b0;
    for (int g = 0; g < 2; g++) begin
      m_dly1[g] = '0; m_dly2[g] = '0; m_out[g] = '0; m_runval[g] = '0; m_run[g] = 0;
    end
    m_pulse = 1'b0; m_busy = 1'b0;

    // Reset, then release with raw A=F: accepted on the 6th edge after release.
    add(1, 4'hF, 4'h0, 0, 3, 4'h0, 4'h0, 0, 0);
    add(0, 4'hF, 4'h0, 0, 5, 4'h0, 4'h0, 1, 0);
    add(0, 4'hF, 4'h0, 0, 1, 4'hF, 4'h0, 0, 1);
    // Clean change A: back to 0, then 0 -> 5.
    add(0, 4'h0, 4'h0, 0, 8, 4'h0, 4'h0, 0, 1);
    add(0, 4'h5, 4'h0, 0, 5, 4'h0, 4'h0, 1, 0);
    add(0, 4'h5, 4'h0, 0, 1, 4'h5, 4'h0, 0, 1);
    add(0, 4'h5, 4'h0, 0, 1, 4'h5, 4'h0, 0, 0);
    // Bounce on B: 3/0 every 2 cycles never reaches the threshold.
    for (int i = 0; i < 10; i++)
      add(0, 4'h5, (i % 2 == 0) ? 4'h3 : 4'h0, 0, 2, 4'h5, 4'h0, -1, 0);
    add(0, 4'h5, 4'h0, 0, 4, 4'h5, 4'h0, 0, 0);
    // Hold: A 0 -> 9 deferred for 12 cycles, then released.
    add(0, 4'h0, 4'h0, 0, 8, 4'h0, 4'h0, 0, 1);
    add(0, 4'h9, 4'h0, 1, 12, 4'h0, 4'h0, 1, 0);
    add(0, 4'h9, 4'h0, 0, 1, 4'h9, 4'h0, 0, 1);
    add(0, 4'h9, 4'h0, 0, 1, 4'h9, 4'h0, 0, 0);
    // Simultaneous change on both groups: one pulse cycle.
    add(0, 4'h2, 4'hC, 0, 5, 4'h9, 4'h0, 1, 0);
    add(0, 4'h2, 4'hC, 0, 1, 4'h2, 4'hC, 0, 1);
    add(0, 4'h2, 4'hC, 0, 1, 4'h2, 4'hC, 0, 0);
    // Reset while A count is at 2; A and B then restart from zero outputs.
    add(0, 4'h7, 4'hC, 0, 4, 4'h2, 4'hC, 1, 0);
    add(1, 4'h7, 4'hC, 0, 1, 4'h0, 4'h0, 0, 0);
    add(0, 4'h7, 4'hC, 0, 5, 4'h0, 4'h0, 1, 0);
    add(0, 4'h7, 4'hC, 0, 1, 4'h7, 4'hC, 0, 1);
    // Back-to-back updates on consecutive edges: pulse stays high 2 cycles.
    add(0, 4'h3, 4'hC, 0, 1, 4'h7, 4'hC, 0, 0);
    add(0, 4'h3, 4'h5, 0, 5, 4'h3, 4'hC, 1, 1);
    add(0, 4'h3, 4'h5, 0, 1, 4'h3, 4'h5, 0, 1);
    add(0, 4'h3, 4'h5, 0, 1, 4'h3, 4'h5, 0, 0);

    foreach (ph[i]) begin
      rst = ph[i].rst; in_a = ph[i].a; in_b = ph[i].b; in_hold = ph[i].hold;
      pulses_seen = 0;
      for (int c = 0; c < ph[i].cycles; c++) tick();
      check($sformatf("phase%0d_one", i), 32'(sw_if.one), 32'(ph[i].exp_one));
      check($sformatf("phase%0d_two", i), 32'(sw_if.two), 32'(ph[i].exp_two));
      check($sformatf("phase%0d_pulses", i), 32'(pulses_seen), 32'(ph[i].exp_pulses));
      if (ph[i].exp_busy >= 0)
        check($sformatf("phase%0d_busy", i), 32'(sw_if.busy), 32'(ph[i].exp_busy));
    end

    // Randomized traffic: sparse raw changes, frequent hold, rare reset.
    for (int n = 0; n < 1500; n++) begin
      rst     = ($urandom_range(0, 149) == 0);
      in_hold = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 6) == 0) in_a = W'($urandom);
      if ($urandom_range(0, 6) == 0) in_b = W'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_io_switch_debounce
